// File: rtl/axi_cmd_pkg.sv
// Shared definitions for axi_cmd_master: FSM state encoding, AXI response
// codes reported on rsp_resp_o, and the fixed channel widths.
package axi_cmd_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_e;

endpackage

// File: rtl/axi_cmd_master.sv
// axi_cmd_master
// Single-outstanding, single-beat AXI master. A command accepted on the
// cmd_* handshake becomes one AXI write (AW+W+B) or one read (AR+R). The
// outcome is returned on the rsp_* handshake. Only one transaction is in
// flight at a time.
//
// Ports
//   clk, areset (async, active-low)
//   cmd_valid_i/cmd_ready_o, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i
//   rsp_valid_o/rsp_ready_i, rsp_write_o, rsp_rdata_o, rsp_resp_o
//   AW: awid_o, awaddr_o, awvalid_o, awready_i
//   W : wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, wready_i
//   B : bid_i, bresp_i, bvalid_i, bready_o
//   AR: arid_o, araddr_o, arvalid_o, arready_i
//   R : rid_i, rdata_i, rlast_i, rvalid_i, rready_o
//
// Build option
//   AXI_CMD_TIMEOUT_EN : when defined, a watchdog aborts a transaction after
//   TIMEOUT_CYCLES cycles spent waiting on the AXI slave. The response code
//   is then 2'b11 and the read data is 0.
module axi_cmd_master
  import axi_cmd_pkg::*;
#(
  parameter logic [ID_W-1:0] ID_VAL         = 4'h0,
  parameter int              TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              areset,
  // command / response
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic [STRB_W-1:0] cmd_wstrb_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_write_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [1:0]        rsp_resp_o,
  // write address
  output logic [ID_W-1:0]   awid_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  // write data
  output logic [ID_W-1:0]   wid_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic              wlast_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  // write response
  input  logic [ID_W-1:0]   bid_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  // read address
  output logic [ID_W-1:0]   arid_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  // read data
  input  logic [ID_W-1:0]   rid_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              write_q, write_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              expired;

`ifdef AXI_CMD_TIMEOUT_EN
  localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W    = (TO_BITS > 8) ? TO_BITS : 8;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // The counter sits at zero in IDLE/RSP, so it is already clear on entry
  // to WR_REQ/RD_REQ and counts every cycle spent waiting on the slave.
  always_comb begin
    to_cnt_d = '0;
    if (state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA}) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Last waiting cycle. A handshake that completes in this cycle still
  // takes priority in the FSM. Otherwise the next state is RSP, so the
  // valids/readys are low from cycle TIMEOUT_CYCLES onwards.
  assign expired = (to_cnt_q >= TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  logic unused_rlast;
  assign unused_rlast = rlast_i;
`else
  assign expired = 1'b0;

  logic unused_ok;
  assign unused_ok = rlast_i ^ TIMEOUT_CYCLES[0];
`endif

  // Fixed ID, single beat, payload straight from the command registers.
  assign awid_o      = ID_VAL;
  assign wid_o       = ID_VAL;
  assign arid_o      = ID_VAL;
  assign awaddr_o    = addr_q;
  assign araddr_o    = addr_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign wlast_o     = 1'b1;
  assign rsp_write_o = write_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_resp_o  = resp_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    write_d     = write_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    awvalid_o   = 1'b0;
    wvalid_o    = 1'b0;
    bready_o    = 1'b0;
    arvalid_o   = 1'b0;
    rready_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          addr_d    = cmd_addr_i;
          wdata_d   = cmd_wdata_i;
          wstrb_d   = cmd_wstrb_i;
          write_d   = cmd_write_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write_i ? WR_REQ : RD_REQ;
        end
      end

      WR_REQ: begin
        // AW and W complete independently; each valid drops after its own
        // handshake and the done flags remember which ones are finished.
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        aw_done_d = aw_done_q | awready_i;
        w_done_d  = w_done_q | wready_i;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end else if (expired) begin
          rdata_d = '0;
          resp_d  = RESP_TIMEOUT;
          state_d = RSP;
        end
      end

      WR_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          rdata_d = '0;
          resp_d  = (bid_i != ID_VAL) ? RESP_SLVERR : bresp_i;
          state_d = RSP;
        end else if (expired) begin
          rdata_d = '0;
          resp_d  = RESP_TIMEOUT;
          state_d = RSP;
        end
      end

      RD_REQ: begin
        arvalid_o = 1'b1;
        if (arready_i) begin
          state_d = RD_DATA;
        end else if (expired) begin
          rdata_d = '0;
          resp_d  = RESP_TIMEOUT;
          state_d = RSP;
        end
      end

      RD_DATA: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          rdata_d = rdata_i;
          resp_d  = (rid_i != ID_VAL) ? RESP_SLVERR : RESP_OKAY;
          state_d = RSP;
        end else if (expired) begin
          rdata_d = '0;
          resp_d  = RESP_TIMEOUT;
          state_d = RSP;
        end
      end

      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

endmodule

// File: tb/tb_axi_cmd_master.sv
// Testbench for axi_cmd_master. The bench plays the AXI slave with
// per-transaction latencies and keeps a reference memory that is updated
// from the commands it issues. Directed transactions are followed by random
// ones. The watchdog scenario is built only when AXI_CMD_TIMEOUT_EN is
// defined (the DUT is built with TIMEOUT_CYCLES = 16).
module tb_axi_cmd_master;

  logic        clk = 1'b0;
  logic        areset;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_wstrb_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_write_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_resp_o;
  logic [3:0]  awid_o, wid_o, arid_o, bid_i, rid_i;
  logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i;
  logic [3:0]  wstrb_o;
  logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o, arvalid_o, arready_i;
  logic        rlast_i, rvalid_i, rready_o;

  axi_cmd_master #(.ID_VAL(4'h0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .areset(areset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
    .rready_o(rready_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Entered in RSP; holds rsp_ready_i low for 'hold' cycles, then consumes.
  task automatic check_rsp(input bit wr, input logic [31:0] rdata, input logic [1:0] resp,
                           input int hold);
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", rsp_valid_o, 1);
      chk("rsp_write", rsp_write_o, wr);
      chk("rsp_rdata", rsp_rdata_o, rdata);
      chk("rsp_resp", rsp_resp_o, resp);
      chk("cmd_ready_in_rsp", cmd_ready_o, 0);
      rsp_ready_i = (i == hold);
      cmd_valid_i = (i == hold) ? 1'b0 : 1'($urandom);
      cmd_write_i = 1'($urandom);
      cmd_addr_i  = $urandom;
      @(negedge clk);
    end
    rsp_ready_i = 1'b0;
    chk("rsp_valid_after", rsp_valid_o, 0);
    chk("cmd_ready_idle", cmd_ready_o, 1);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, input logic [3:0] bid, input logic [1:0] bresp,
                           input int hold);
    bit          aw_done, w_done, b_done;
    logic [31:0] cap_addr, cap_data;
    logic [3:0]  cap_strb;
    int          n;
    chk("wr_cmd_ready", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1;
    cmd_addr_i = addr; cmd_wdata_i = data; cmd_wstrb_i = strb;
    @(negedge clk);
    cmd_valid_i = 1'b0; cmd_addr_i = $urandom; cmd_wdata_i = $urandom; cmd_wstrb_i = 4'($urandom);
    chk("wr_cmd_ready_busy", cmd_ready_o, 0);
    chk("awvalid_first", awvalid_o, 1);
    chk("wvalid_first", wvalid_o, 1);
    aw_done = 0; w_done = 0; b_done = 0; n = 0;
    cap_addr = '0; cap_data = '0; cap_strb = '0;
    while (!b_done && n < 60) begin
      chk("awvalid", awvalid_o, !aw_done);
      chk("wvalid", wvalid_o, !w_done);
      if (!aw_done) chk("awaddr", awaddr_o, addr);
      if (!w_done) begin
        chk("wdata", wdata_o, data);
        chk("wstrb", wstrb_o, strb);
        chk("wlast", wlast_o, 1);
      end
      chk("bready", bready_o, aw_done && w_done);
      awready_i = (n >= aw_dly);
      wready_i  = (n >= w_dly);
      bvalid_i  = (n >= b_dly);
      bid_i = bid; bresp_i = bresp;
      cmd_valid_i = 1'($urandom); cmd_write_i = 1'($urandom);
      if (bready_o && bvalid_i) b_done = 1;
      if (awvalid_o && awready_i) begin cap_addr = awaddr_o; aw_done = 1; end
      if (wvalid_o && wready_i) begin cap_data = wdata_o; cap_strb = wstrb_o; w_done = 1; end
      @(negedge clk);
      n++;
    end
    chk("b_handshake_seen", b_done, 1);
    awready_i = 0; wready_i = 0; bvalid_i = 0; bid_i = $urandom; bresp_i = $urandom;
    slv_mem[cap_addr] = merge(slv_rd(cap_addr), cap_data, cap_strb);
    ref_mem[addr]     = merge(ref_rd(addr), data, strb);
    check_rsp(1'b1, 32'h0, (bid != 4'h0) ? 2'b10 : bresp, hold);
  endtask

  task automatic run_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          input logic [3:0] rid, input int hold);
    bit          ar_done, r_done;
    logic [31:0] cap_addr;
    int          n, r_cnt;
    chk("rd_cmd_ready", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = addr; cmd_wdata_i = $urandom;
    @(negedge clk);
    cmd_valid_i = 1'b0; cmd_addr_i = $urandom;
    chk("arvalid_first", arvalid_o, 1);
    ar_done = 0; r_done = 0; n = 0; r_cnt = 0; cap_addr = '0;
    while (!r_done && n < 60) begin
      chk("arvalid", arvalid_o, !ar_done);
      if (!ar_done) chk("araddr", araddr_o, addr);
      chk("rready", rready_o, ar_done);
      chk("bready_in_read", bready_o, 0);
      arready_i = (n >= ar_dly);
      rvalid_i  = ar_done && (r_cnt >= r_dly);
      rid_i     = rvalid_i ? rid : 4'($urandom);
      rdata_i   = rvalid_i ? slv_rd(cap_addr) : $urandom;
      rlast_i   = 1'($urandom);
      cmd_valid_i = 1'($urandom); cmd_write_i = 1'($urandom);
      if (ar_done) r_cnt++;
      if (rready_o && rvalid_i) r_done = 1;
      if (arvalid_o && arready_i) begin cap_addr = araddr_o; ar_done = 1; end
      @(negedge clk);
      n++;
    end
    chk("r_handshake_seen", r_done, 1);
    arready_i = 0; rvalid_i = 0; rdata_i = $urandom;
    check_rsp(1'b0, ref_rd(addr), (rid != 4'h0) ? 2'b10 : 2'b00, hold);
  endtask

  task automatic reset_mid_write();
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h10;
    cmd_wdata_i = 32'h1234_5678; cmd_wstrb_i = 4'hF;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_pre_awvalid", awvalid_o, 1);
    #2 areset = 1'b0;
    #1;
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_wvalid", wvalid_o, 0);
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    @(negedge clk);
    areset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_cmd_ready", cmd_ready_o, 1);
      chk("post_rst_rsp_valid", rsp_valid_o, 0);
      chk("post_rst_awvalid", awvalid_o, 0);
    end
  endtask

`ifdef AXI_CMD_TIMEOUT_EN
  task automatic read_timeout();
    int n;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h20;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    arready_i = 1'b0;
    n = 0;
    while (arvalid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("to_arvalid_cycles", n, 16);
    chk("to_rready", rready_o, 0);
    check_rsp(1'b0, 32'h0, 2'b11, 1);
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_chk);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  id;
    areset = 1'b0;
    cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = 0; cmd_wdata_i = 0; cmd_wstrb_i = 0;
    rsp_ready_i = 0; awready_i = 0; wready_i = 0; bid_i = 0; bresp_i = 0; bvalid_i = 0;
    arready_i = 0; rid_i = 0; rdata_i = 0; rlast_i = 0; rvalid_i = 0;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready_o, 1);
    chk("reset_awvalid", awvalid_o, 0);
    chk("reset_wvalid", wvalid_o, 0);
    chk("reset_arvalid", arvalid_o, 0);
    chk("reset_bready", bready_o, 0);
    chk("reset_rready", rready_o, 0);
    chk("reset_rsp_valid", rsp_valid_o, 0);
    chk("reset_awaddr", awaddr_o, 0);
    chk("reset_wdata", wdata_o, 0);
    chk("reset_wlast", wlast_o, 1);
    chk("reset_rsp_resp", rsp_resp_o, 0);
    chk("reset_awid", awid_o, 0);
    areset = 1'b1;
    @(negedge clk);

    run_write(32'h3, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 4'h0, 2'b00, 0);
    run_read(32'h3, 0, 3, 4'h0, 4);
    run_write(32'h8, 32'hCAFE_F00D, 4'hF, 0, 5, 1, 4'h0, 2'b00, 1);
    run_read(32'h8, 1, 0, 4'h5, 0);
    run_write(32'h3, 32'h0000_AA00, 4'h2, 2, 0, 3, 4'h0, 2'b00, 0);
    run_read(32'h3, 0, 0, 4'h0, 0);

    for (int t = 0; t < 40; t++) begin
      a  = 32'($urandom_range(0, 7));
      id = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        run_write(a, d, 4'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 6), id, 2'($urandom), $urandom_range(0, 3));
      end else begin
        run_read(a, $urandom_range(0, 4), $urandom_range(0, 4), id, $urandom_range(0, 3));
      end
    end

    reset_mid_write();
    run_read(32'h3, 0, 1, 4'h0, 0);

`ifdef AXI_CMD_TIMEOUT_EN
    read_timeout();
    run_read(32'h8, 15, 0, 4'h0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
